chan_dump_eng: RTL

Parametrised channel-dump engine for the logic-analyzer digital core. After capture completes, it reads one selected channel RAM in chronological order, starting at the oldest sample and wrapping circularly. Each byte is handed to the UART transmitter through a trmt/tx_done handshake. It replaces the fixed 5-channel, 384-entry dump path and adds oldest-first unwrapping, abort, and request-error reporting.

---
 rtl/chan_dump_eng.sv | 83 ++++++++
 1 files changed

// File: rtl/chan_dump_eng.sv
// chan_dump_eng: dumps one channel RAM oldest-first to the UART via a trmt/tx_done handshake
// Ports: clk/rst_n (async active-low); dump_req/dump_ch/trig_addr/capt_done request a dump;
//   abort ends it early; ram_addr/ram_rd_en/ram_rdata read the channel RAMs (1-cycle latency);
//   tx_data/trmt/tx_done talk to the transmitter; dumping/dump_done/bad_req report status.
module chan_dump_eng #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9,
  parameter int NUM_CH  = 5,
  parameter int CH_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dump_req,
  input  logic [CH_W-1:0]       dump_ch,
  input  logic [LOG2-1:0]       trig_addr,
  input  logic                  capt_done,
  input  logic                  abort,
  output logic [LOG2-1:0]       ram_addr,
  output logic                  ram_rd_en,
  input  logic [8*NUM_CH-1:0]   ram_rdata,
  output logic [7:0]            tx_data,
  output logic                  trmt,
  input  logic                  tx_done,
  output logic                  dumping,
  output logic                  dump_done,
  output logic                  bad_req
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, SEND = 2'd2, WAIT = 2'd3;
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  logic [1:0] state;
  logic [CH_W-1:0] ch;
  logic [LOG2-1:0] cur_addr, cnt;
  logic [7:0] tx_q, sel;
  logic ok;
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_CH; k++) if (ch == CH_W'(k)) sel = ram_rdata[8*k +: 8];
  end
  assign ok        = capt_done && dump_ch <= CH_LAST && trig_addr <= LAST;
  assign ram_addr  = cur_addr;
  assign ram_rd_en = state == RD;
  assign trmt      = state == SEND;
  assign dumping   = state != IDLE;
  // RAM data only arrives in SEND, so the live slice is forwarded during the strobe and held afterwards
  assign tx_data   = trmt ? sel : tx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      cur_addr  <= '0;
      cnt       <= '0;
      tx_q      <= '0;
      dump_done <= 1'b0;
      bad_req   <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      bad_req   <= 1'b0;
      if (state == SEND) tx_q <= sel;
      if (state != IDLE && abort) state <= IDLE;
      else if (state == IDLE) begin
        bad_req <= dump_req && !ok;
        if (dump_req && ok) begin
          state    <= RD;
          ch       <= dump_ch;
          cur_addr <= trig_addr;
          cnt      <= '0;
        end
      end else if (state == RD) state <= SEND;
      else if (state == SEND) state <= WAIT;
      else if (tx_done) begin
        if (cnt == LAST) begin
          dump_done <= 1'b1;
          state     <= IDLE;
        end else begin
          cnt      <= cnt + 1'b1;
          cur_addr <= cur_addr == LAST ? '0 : cur_addr + 1'b1;
          state    <= RD;
        end
      end
    end
  end
endmodule
